// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

   localparam int RF_DATA_W   = 16;
   localparam int RF_NUM_REGS = 8;
   localparam int RF_NUM_RD   = 2;
   localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;

   // Bit offset of port 'port' inside a packed bus of 'width'-bit fields.
   function automatic int port_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// Latency: busy_vec updates one clock after iss_en/wr_en; iss_waw is combinational.
// Backpressure: none; every issue and writeback is accepted in the cycle presented.
//
// Ports: clk/rst (sync, active-high), iss_en/iss_addr (mark pending),
//        wr_en/wr_addr (complete), busy_vec (state), iss_waw (issue onto busy reg).
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = RF_NUM_REGS,
   parameter  int ZERO_REG = 1,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iss_en,
   input  logic [ADDR_W-1:0]   iss_addr,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                iss_waw
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_nxt;

   // Set has priority over clear: a freshly issued producer supersedes the
   // one completing in the same cycle, so the register stays pending.
   always_comb begin
      busy_nxt = busy_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (iss_en && (iss_addr == ADDR_W'(r)))
            busy_nxt[r] = 1'b1;
         else if (wr_en && (wr_addr == ADDR_W'(r)))
            busy_nxt[r] = 1'b0;
      end
      if (ZERO_REG != 0)
         busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_nxt;
   end

   assign busy_vec = busy_q;
   // Uses the pre-update state; register 0 can never be busy when hardwired.
   assign iss_waw  = iss_en & busy_q[iss_addr];

endmodule

// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, write bypass and pending-write scoreboard.
// Latency: reads 0 cycles (bypass gives same-cycle write data); writes visible next cycle.
// Backpressure: none; hazards are reported via rd_busy/iss_waw for the core to stall on.
//
// Ports: clk/rst (sync, active-high); rd_addr/rd_data/rd_busy packed per read port;
//        wr_en/wr_addr/wr_data writeback; iss_en/iss_addr mark destination pending;
//        iss_waw issue onto an already pending register; busy_vec raw scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = RF_DATA_W,
   parameter  int NUM_REGS = RF_NUM_REGS,
   parameter  int NUM_RD   = RF_NUM_RD,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     iss_waw,
   output logic [NUM_REGS-1:0]      busy_vec
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wr_ok;

   // A write takes effect (and may be forwarded) only outside reset and
   // never targets the hardwired zero register.
   assign wr_ok = wr_en && !rst && !((ZERO_REG != 0) && (wr_addr == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs[r] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .busy_vec (busy_vec),
      .iss_waw  (iss_waw)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              hit;
      logic              zero_ra;

      assign ra      = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
      assign zero_ra = (ZERO_REG != 0) && (ra == '0);
      assign hit     = (BYPASS != 0) && wr_ok && (wr_addr == ra);

      assign rd_data[port_lsb(i, DATA_W) +: DATA_W] =
         zero_ra ? '0 : (hit ? wr_data : regs[ra]);
      // The producer completing this cycle satisfies the read via bypass.
      assign rd_busy[i] = busy_vec[ra] & ~hit;
   end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- default build (16b x 8, 2 ports, bypass) ----------------
   logic [5:0]  d_rd_addr = '0;
   logic [31:0] d_rd_data;
   logic [1:0]  d_rd_busy;
   logic        d_wr_en = 1'b0;
   logic [2:0]  d_wr_addr = '0;
   logic [15:0] d_wr_data = '0;
   logic        d_iss_en = 1'b0;
   logic [2:0]  d_iss_addr = '0;
   logic        d_iss_waw;
   logic [7:0]  d_busy_vec;

   regfile_sb u_dut (
      .clk(clk), .rst(rst), .rd_addr(d_rd_addr), .rd_data(d_rd_data), .rd_busy(d_rd_busy),
      .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
      .iss_en(d_iss_en), .iss_addr(d_iss_addr), .iss_waw(d_iss_waw), .busy_vec(d_busy_vec)
   );

   // ---------------- bypass-disabled build ----------------
   logic [5:0]  n_rd_addr = '0;
   logic [31:0] n_rd_data;
   logic [1:0]  n_rd_busy;
   logic        n_wr_en = 1'b0;
   logic [2:0]  n_wr_addr = '0;
   logic [15:0] n_wr_data = '0;
   logic        n_iss_waw;
   logic [7:0]  n_busy_vec;

   regfile_sb #(.BYPASS(0)) u_nb (
      .clk(clk), .rst(rst), .rd_addr(n_rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
      .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
      .iss_en(1'b0), .iss_addr(3'd0), .iss_waw(n_iss_waw), .busy_vec(n_busy_vec)
   );

   // ---------------- wide build (32b x 32, 3 ports) ----------------
   logic [14:0] w_rd_addr = '0;
   logic [95:0] w_rd_data;
   logic [2:0]  w_rd_busy;
   logic        w_wr_en = 1'b0;
   logic [4:0]  w_wr_addr = '0;
   logic [31:0] w_wr_data = '0;
   logic        w_iss_en = 1'b0;
   logic [4:0]  w_iss_addr = '0;
   logic        w_iss_waw;
   logic [31:0] w_busy_vec;

   regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(3)) u_wide (
      .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
      .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
      .iss_en(w_iss_en), .iss_addr(w_iss_addr), .iss_waw(w_iss_waw), .busy_vec(w_busy_vec)
   );

   // Inputs change right after a falling edge; the next rising edge commits them.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic d_drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                          input logic ie, input logic [2:0] ia,
                          input logic [2:0] ra1, input logic [2:0] ra0);
      d_wr_en = we; d_wr_addr = wa; d_wr_data = wd;
      d_iss_en = ie; d_iss_addr = ia;
      d_rd_addr = {ra1, ra0};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      d_drive(0, 0, 0, 0, 0, 3'd3, 3'd3);
      #1;
      checks++; if (d_busy_vec !== 8'h00) begin errors++; $display("FAIL reset_busy_vec: got %h want 00", d_busy_vec); end
      checks++; if (d_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", d_rd_data); end
      checks++; if ({d_rd_busy, d_iss_waw} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {d_rd_busy, d_iss_waw}); end
      d_drive(1, 3'd3, 16'hBEEF, 0, 0, 3'd3, 3'd3);
      step();
      d_drive(0, 0, 0, 1, 3'd3, 3'd3, 3'd3);
      #1;
      checks++; if (d_rd_data[15:0] !== 16'hBEEF) begin errors++; $display("FAIL reset_pre_write: got %h want beef", d_rd_data[15:0]); end
      step();
      // Reset must dominate a write and an issue presented in the same cycle.
      rst = 1'b1;
      d_drive(1, 3'd3, 16'h1111, 1, 3'd5, 3'd3, 3'd3);
      step();
      rst = 1'b0;
      d_drive(0, 0, 0, 0, 0, 3'd3, 3'd3);
      #1;
      checks++; if (d_rd_data[15:0] !== 16'h0000) begin errors++; $display("FAIL reset_r3_cleared: got %h want 0000", d_rd_data[15:0]); end
      checks++; if (d_busy_vec !== 8'h00) begin errors++; $display("FAIL reset_busy_cleared: got %h want 00", d_busy_vec); end
   endtask

   task automatic test_zero_reg();
      d_drive(1, 3'd0, 16'h1234, 0, 0, 3'd0, 3'd0);
      #1;
      checks++; if (d_rd_data !== 32'h0) begin errors++; $display("FAIL zero_no_bypass: got %h want 0", d_rd_data); end
      step();
      d_drive(0, 0, 0, 1, 3'd0, 3'd0, 3'd0);
      #1;
      checks++; if (d_rd_data !== 32'h0) begin errors++; $display("FAIL zero_not_stored: got %h want 0", d_rd_data); end
      step();
      d_drive(1, 3'd0, 16'h5555, 1, 3'd0, 3'd0, 3'd0);
      #1;
      checks++; if ({d_iss_waw, d_busy_vec[0]} !== 2'b00) begin errors++; $display("FAIL zero_never_busy: got %b want 00", {d_iss_waw, d_busy_vec[0]}); end
      step();
      d_drive(0, 0, 0, 0, 0, 3'd0, 3'd0);
      #1;
      checks++; if ({d_busy_vec[0], d_rd_busy} !== 3'b000) begin errors++; $display("FAIL zero_busy_after: got %b want 000", {d_busy_vec[0], d_rd_busy}); end
   endtask

   task automatic test_bypass();
      d_drive(1, 3'd5, 16'hA5A5, 0, 0, 3'd5, 3'd5);
      n_wr_en = 1'b1; n_wr_addr = 3'd5; n_wr_data = 16'hA5A5; n_rd_addr = {3'd5, 3'd5};
      #1;
      checks++; if (d_rd_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_same_cycle: got %h want a5a5a5a5", d_rd_data); end
      checks++; if (n_rd_data !== 32'h00000000) begin errors++; $display("FAIL nobypass_old_value: got %h want 00000000", n_rd_data); end
      step();
      d_drive(0, 0, 0, 0, 0, 3'd5, 3'd5);
      n_wr_en = 1'b0;
      #1;
      checks++; if (d_rd_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_stored: got %h want a5a5a5a5", d_rd_data); end
      checks++; if (n_rd_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL nobypass_next_cycle: got %h want a5a5a5a5", n_rd_data); end
   endtask

   task automatic test_raw();
      d_drive(0, 0, 0, 1, 3'd2, 3'd2, 3'd0);
      #1;
      checks++; if (d_iss_waw !== 1'b0) begin errors++; $display("FAIL raw_first_issue_waw: got %b want 0", d_iss_waw); end
      step();
      d_drive(0, 0, 0, 0, 0, 3'd2, 3'd0);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if ({d_busy_vec[2], d_rd_busy} !== 3'b110) begin errors++; $display("FAIL raw_pending_%0d: got %b want 110", k, {d_busy_vec[2], d_rd_busy}); end
         step();
      end
      d_drive(1, 3'd2, 16'h0042, 0, 0, 3'd2, 3'd0);
      #1;
      checks++; if (d_rd_busy !== 2'b00) begin errors++; $display("FAIL raw_wb_busy: got %b want 00", d_rd_busy); end
      checks++; if (d_rd_data[31:16] !== 16'h0042) begin errors++; $display("FAIL raw_wb_data: got %h want 0042", d_rd_data[31:16]); end
      step();
      d_drive(0, 0, 0, 0, 0, 3'd2, 3'd0);
      #1;
      checks++; if (d_busy_vec[2] !== 1'b0) begin errors++; $display("FAIL raw_cleared: got %b want 0", d_busy_vec[2]); end
   endtask

   task automatic test_collision();
      d_drive(0, 0, 0, 1, 3'd4, 3'd0, 3'd4);
      step();
      d_drive(1, 3'd4, 16'h7777, 1, 3'd4, 3'd0, 3'd4);
      #1;
      checks++; if (d_iss_waw !== 1'b1) begin errors++; $display("FAIL collide_waw: got %b want 1", d_iss_waw); end
      step();
      d_drive(0, 0, 0, 0, 0, 3'd0, 3'd4);
      #1;
      checks++; if (d_busy_vec !== 8'h10) begin errors++; $display("FAIL collide_set_wins: got %h want 10", d_busy_vec); end
      checks++; if ({d_rd_busy[0], d_rd_data[15:0]} !== {1'b1, 16'h7777}) begin errors++; $display("FAIL collide_data: got %b/%h want 1/7777", d_rd_busy[0], d_rd_data[15:0]); end
      // Write to a register that is not pending: stored, stays non-busy.
      d_drive(1, 3'd6, 16'h005A, 0, 0, 3'd6, 3'd4);
      step();
      d_drive(0, 0, 0, 0, 0, 3'd6, 3'd4);
      #1;
      checks++; if ({d_busy_vec[6], d_rd_data[31:16]} !== {1'b0, 16'h005A}) begin errors++; $display("FAIL nonbusy_write: got %b/%h want 0/005a", d_busy_vec[6], d_rd_data[31:16]); end
   endtask

   // Random streams on the wide build against an array model of the rules.
   task automatic test_random_wide();
      logic [31:0] mdl_regs [32];
      bit          mdl_busy [32];
      logic [31:0] exp_busy_vec;
      logic [31:0] exp_d;
      logic [4:0]  a;
      logic        exp_b;
      logic        exp_waw;
      for (int r = 0; r < 32; r++) begin mdl_regs[r] = '0; mdl_busy[r] = 0; end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         rst = (cyc == 5000) || ($urandom_range(0, 499) == 0);
         w_wr_en    = ($urandom_range(0, 1) == 1);
         w_wr_addr  = 5'($urandom_range(0, 31));
         w_wr_data  = $urandom;
         w_iss_en   = ($urandom_range(0, 9) < 3);
         w_iss_addr = 5'($urandom_range(0, 31));
         for (int p = 0; p < 3; p++)
            w_rd_addr[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? w_wr_addr : 5'($urandom_range(0, 31));
         #1;
         if (!rst) begin
            for (int p = 0; p < 3; p++) begin
               a = w_rd_addr[p*5 +: 5];
               if (a == 0)                           exp_d = '0;
               else if (w_wr_en && w_wr_addr == a)   exp_d = w_wr_data;
               else                                  exp_d = mdl_regs[a];
               exp_b = mdl_busy[a] && !(w_wr_en && w_wr_addr == a);
               checks++; if (w_rd_data[p*32 +: 32] !== exp_d) begin errors++; $display("FAIL rand_rd_data cyc=%0d port=%0d: got %h want %h", cyc, p, w_rd_data[p*32 +: 32], exp_d); end
               checks++; if (w_rd_busy[p] !== exp_b) begin errors++; $display("FAIL rand_rd_busy cyc=%0d port=%0d: got %b want %b", cyc, p, w_rd_busy[p], exp_b); end
            end
            exp_waw = w_iss_en && mdl_busy[w_iss_addr];
            for (int r = 0; r < 32; r++) exp_busy_vec[r] = mdl_busy[r];
            checks++; if (w_iss_waw !== exp_waw) begin errors++; $display("FAIL rand_iss_waw cyc=%0d: got %b want %b", cyc, w_iss_waw, exp_waw); end
            checks++; if (w_busy_vec !== exp_busy_vec) begin errors++; $display("FAIL rand_busy_vec cyc=%0d: got %h want %h", cyc, w_busy_vec, exp_busy_vec); end
         end
         // Model update for the coming rising edge.
         if (rst) begin
            for (int r = 0; r < 32; r++) begin mdl_regs[r] = '0; mdl_busy[r] = 0; end
         end else begin
            if (w_wr_en && w_wr_addr != 0) mdl_regs[w_wr_addr] = w_wr_data;
            if (w_wr_en) mdl_busy[w_wr_addr] = 0;
            if (w_iss_en && w_iss_addr != 0) mdl_busy[w_iss_addr] = 1;
         end
         step();
      end
      rst = 1'b0;
      w_wr_en = 1'b0;
      w_iss_en = 1'b0;
   endtask

   initial begin
      step();
      test_reset();
      test_zero_reg();
      test_bypass();
      test_raw();
      test_collision();
      test_random_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the RISC-16 register file.
- Generic width, depth and read-port count; optional hardwired-zero register; write-to-read bypass.
- Integrated pending-write scoreboard so a pipelined core can detect RAW/WAW hazards on in-flight loads.
- Sits between decode (read and issue) and writeback (write) in the pipelined RISC-16 core.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of architectural registers (power of two, >=2).
- NUM_RD, 2, number of independent combinational read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never becomes busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- ADDR_W, $clog2(NUM_REGS), derived; not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  1 = register on port i has an outstanding write not satisfied this cycle.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback target.
- wr_data  in  DATA_W  writeback value.
- iss_en  in  1  decode issued an instruction that will later write iss_addr.
- iss_addr  in  ADDR_W  destination being marked pending.
- iss_waw  out  1  iss_en while iss_addr already busy (informational).
- busy_vec  out  NUM_REGS  raw scoreboard bits, for debug/stall logic.

Behaviour:
- Reset: clk and rst are one clock, with synchronous active-high reset. On a rising edge with rst=1, all registers go to 0 and all busy bits go to 0. rst dominates wr_en and iss_en in that cycle. After that edge, rd_data=0, rd_busy=0, busy_vec=0 and iss_waw=0 (given iss_en=0).
- Storage: write occurs on a rising edge when wr_en=1 and rst=0. Latency 1: the stored value is visible via the array the next cycle.
- ZERO_REG=1:
  - writes with wr_addr=0 are dropped;
  - reads of address 0 return 0 regardless of bypass;
  - iss_en with iss_addr=0 is ignored;
  - busy_vec[0] is always 0.
- Read: rd_data[i] = regs[rd_addr[i]], purely combinational, no clock latency.
- Bypass (BYPASS=1): if wr_en=1, rst=0 and wr_addr==rd_addr[i] (and not the zero register), then rd_data[i]=wr_data in the same cycle. All ports bypass independently; several ports may hit the same address.
- Bypass disabled (BYPASS=0): reads return the pre-write value until the next cycle.
- Scoreboard, next-state per register r on a rising edge with rst=0:
  - set if iss_en and iss_addr==r;
  - else clear if wr_en and wr_addr==r;
  - else hold.
  - Simultaneous set and clear on the same r: set wins (a new producer supersedes the completing one).
- rd_busy[i] = busy[rd_addr[i]] AND NOT (BYPASS and wr_en and wr_addr==rd_addr[i]). With BYPASS=0, the busy bit alone drives rd_busy.
- iss_waw = iss_en AND busy[iss_addr] (combinational, pre-update). The set still happens.
- Write to a non-busy register is legal: data is stored, busy stays 0.
- Address width: all addresses are exactly ADDR_W, so no out-of-range case exists.
- Mid-operation reset: pending bits and data are lost. No write or issue presented in the rst cycle takes effect.

Decomposition:
- Package regfile_pkg:
  - default constants RF_DATA_W=16, RF_NUM_REGS=8, RF_NUM_RD=2;
  - typedef rf_addr_t for the default ADDR_W;
  - helper function for packed-port slice offsets.
- Sub-module regfile_scoreboard (NUM_REGS, ZERO_REG):
  - owns the busy vector, the set/clear priority and iss_waw;
  - instantiated once by regfile_sb.
- Data array, read mux and bypass stay in regfile_sb.

Test Plan:
- Reset clear: write 0xBEEF to r3, pulse rst for one cycle -> next cycle rd_data(r3)=0x0000, busy_vec=0.
- Zero register: wr_en, wr_addr=0, wr_data=0x1234, then iss_en iss_addr=0 -> rd_data(r0)=0 on all ports, busy_vec[0]=0 throughout.
- Bypass:
  - cycle N: wr_en r5=0xA5A5 with rd_addr0=rd_addr1=5 -> both rd_data=0xA5A5 in cycle N;
  - BYPASS=0 build -> old value 0x0000 in cycle N, 0xA5A5 in N+1.
- Scoreboard RAW:
  - iss_en r2 at cycle 1 -> busy_vec[2]=1 and rd_busy=1 for a port reading r2 in cycles 2..k;
  - wr_en r2=0x0042 at cycle k -> rd_busy=0 with rd_data=0x0042 in cycle k, busy_vec[2]=0 at k+1.
- Set/clear collision: r4 busy; same cycle wr_en r4 and iss_en r4 -> iss_waw=1, busy_vec[4] stays 1, r4 holds written value.
- Parameter sweep: DATA_W=32, NUM_REGS=32, NUM_RD=3, random issue/write/read streams vs reference model -> zero mismatches over 10k cycles, including rst asserted mid-stream.
